// File: rtl/crc32_pkg.sv
// crc32_pkg: shared constants and FSM state type for the CRC-32 stream controller.
//   CRC32_POLY    reflected IEEE 802.3 polynomial
//   CRC32_INIT    register seed for the first byte of a frame
//   CRC32_RESIDUE raw register value left by a frame that carries its own valid CRC
package crc32_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/crc32_byte_step.sv
// crc32_byte_step: combinational single-byte CRC-32 update (LSB first, reflected).
// Ports:
//   crc_in  [31:0]  running raw CRC register
//   data    [7:0]   message byte
//   crc_out [31:0]  register after absorbing the byte
module crc32_byte_step
    import crc32_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ (c[0] ? CRC32_POLY : 32'h0);
        end
        crc_out = c;
    end

endmodule

// File: rtl/crc32_stream_ctrl.sv
// crc32_stream_ctrl: framed byte-stream CRC-32 engine with valid/ready in and out.
// Optional build macro: CRC32_CHECK_EN adds out_ok (frame residue check).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         input byte handshake, in_data byte, in_last marks frame end
//   out_valid/out_ready       result handshake
//   out_crc [31:0]            finished (inverted) CRC of the frame
//   out_len [LEN_W-1:0]       frame byte count, saturating
//   out_ok                    raw register equals the CRC residue (CRC32_CHECK_EN only)
//
// state | meaning
// IDLE  | waiting for the first byte of a frame; CRC seeded from CRC32_INIT
// RUN   | mid-frame, absorbing one byte per accept
// DONE  | result held on out_* until the consumer takes it
module crc32_stream_ctrl
    import crc32_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_crc,
    output logic [LEN_W-1:0] out_len,
    input  logic             out_ready
`ifdef CRC32_CHECK_EN
    ,
    output logic             out_ok
`endif
);

    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    state_t           state_q, state_d;
    logic [31:0]      crc_q, seed, crc_step;
    logic [LEN_W-1:0] len_q;
    logic             accept;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = in_last ? DONE : RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                if (in_valid && in_last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign seed   = (state_q == IDLE) ? CRC32_INIT : crc_q;

    crc32_byte_step u_step (
        .crc_in  (seed),
        .data    (in_data),
        .crc_out (crc_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            crc_q   <= CRC32_INIT;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                crc_q <= crc_step;
                if (state_q == IDLE) begin
                    len_q <= LEN_W'(1);
                end else if (len_q != LEN_MAX) begin
                    len_q <= len_q + LEN_W'(1);
                end
            end
        end
    end

    assign out_crc = ~crc_q;
    assign out_len = len_q;

`ifdef CRC32_CHECK_EN
    assign out_ok = (crc_q == CRC32_RESIDUE);
`endif

endmodule

// File: tb/tb_crc32_stream_ctrl.sv
// Self-checking bench for crc32_stream_ctrl. Two instances share stimulus:
// LEN_W=16 and LEN_W=2 (length saturation). A queue-based frame model predicts
// handshake and result every cycle; directed frames pin the model to known CRCs.
module tb_crc32_stream_ctrl;

    typedef logic [7:0] u8_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_last, out_ready;
    logic [7:0]  in_data;
    logic        in_ready, out_valid, in_ready2, out_valid2;
    logic [31:0] out_crc, out_crc2;
    logic [15:0] out_len;
    logic [1:0]  out_len2;
`ifdef CRC32_CHECK_EN
    logic        out_ok, out_ok2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    crc32_stream_ctrl #(.LEN_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .out_valid(out_valid), .out_crc(out_crc), .out_len(out_len),
        .out_ready(out_ready)
`ifdef CRC32_CHECK_EN
        , .out_ok(out_ok)
`endif
    );

    crc32_stream_ctrl #(.LEN_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready2), .out_valid(out_valid2), .out_crc(out_crc2), .out_len(out_len2),
        .out_ready(out_ready)
`ifdef CRC32_CHECK_EN
        , .out_ok(out_ok2)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference CRC-32 of a whole frame (final value, inverted).
    function automatic logic [31:0] crc_of(input u8_t b[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Behavioural model: bytes of the frame in progress, and the pending result.
    u8_t         frame_q[$];
    bit          pend = 0;
    logic [31:0] pend_crc;
    int          pend_len;
    bit          started = 0;

    always @(posedge clk) begin
        if (rst) begin
            frame_q.delete();
            pend = 0;
        end else if (pend) begin
            if (out_ready) pend = 0;
        end else if (in_valid) begin
            frame_q.push_back(in_data);
            if (in_last) begin
                pend     = 1;
                pend_crc = crc_of(frame_q);
                pend_len = frame_q.size();
                frame_q.delete();
            end
        end
    end

    logic [31:0] xfer_crc[$];
    int          xfer_len[$];
    int          xfer_len2[$];
    bit          xfer_ok[$];

    always @(negedge clk) begin
        if (started && !rst) begin
            check("in_ready", {31'h0, in_ready}, {31'h0, !pend});
            check("out_valid", {31'h0, out_valid}, {31'h0, pend});
            check("in_ready_w2", {31'h0, in_ready2}, {31'h0, !pend});
            check("out_valid_w2", {31'h0, out_valid2}, {31'h0, pend});
            if (pend) begin
                check("out_crc", out_crc, pend_crc);
                check("out_len", {16'h0, out_len}, (pend_len > 65535) ? 32'd65535 : 32'(pend_len));
                check("out_crc_w2", out_crc2, pend_crc);
                check("out_len_w2", {30'h0, out_len2}, (pend_len > 3) ? 32'd3 : 32'(pend_len));
`ifdef CRC32_CHECK_EN
                check("out_ok", {31'h0, out_ok}, {31'h0, pend_crc == 32'h2144DF1C});
`endif
            end
            if (out_valid && out_ready) begin
                xfer_crc.push_back(out_crc);
                xfer_len.push_back(int'(out_len));
                xfer_len2.push_back(int'(out_len2));
`ifdef CRC32_CHECK_EN
                xfer_ok.push_back(out_ok);
`else
                xfer_ok.push_back(1'b0);
`endif
            end
        end
    end

    task automatic send_frame(input u8_t b[$], input int gap_pct, input bit use_last,
                              output int stall_first);
        int n;
        bit r;
        stall_first = 0;
        for (int i = 0; i < b.size(); i++) begin
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = b[i];
            in_last  = use_last && (i == b.size() - 1);
            n = 0;
            forever begin
                @(negedge clk);
                r = in_ready;
                @(posedge clk); #1;
                if (r) break;
                n++;
                if (n > 50) begin
                    n_tests++; n_fail++;
                    $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
                    break;
                end
            end
            if (i == 0) stall_first = n;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_xfer(input int hold);
        int n0, k;
        n0 = xfer_crc.size();
        k  = 0;
        while (!(out_valid || xfer_crc.size() > n0) && k < 60) begin
            @(posedge clk); #1; k++;
        end
        if (xfer_crc.size() == n0) begin
            repeat (hold) begin @(posedge clk); #1; end
            out_ready = 1'b1;
            k = 0;
            while (xfer_crc.size() == n0 && k < 60) begin
                @(posedge clk); #1; k++;
            end
        end
        if (xfer_crc.size() == n0) begin
            n_tests++; n_fail++;
            $display("FAIL xfer_timeout: got no transfer expected one within 60 cycles");
            xfer_crc.push_back('x); xfer_len.push_back(-1); xfer_len2.push_back(-1); xfer_ok.push_back(1'b0);
        end
        out_ready = 1'b0;
    endtask

    u8_t q_a[$], q_num[$], q_zero[$], q_part[$], q_rnd[$], q_chk[$];
    int  stall;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h0; in_last = 1'b0; out_ready = 1'b0;
        q_a    = '{8'h61};
        q_num  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        q_zero = '{8'h00};
        q_part = '{8'h31, 8'h32, 8'h33, 8'h34};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        started = 1;

        @(negedge clk);
        check("reset_in_ready", {31'h0, in_ready}, 32'd1);
        check("reset_out_valid", {31'h0, out_valid}, 32'd0);
        check("reset_out_crc", out_crc, 32'h0);
        check("reset_out_len", {16'h0, out_len}, 32'd0);
`ifdef CRC32_CHECK_EN
        check("reset_out_ok", {31'h0, out_ok}, 32'd0);
`endif
        @(posedge clk); #1;

        send_frame(q_a, 0, 1'b1, stall);
        wait_xfer(0);
        check("a_crc", xfer_crc[$], 32'hE8B7BE43);
        check("a_len", 32'(xfer_len[$]), 32'd1);
        @(posedge clk); #1;

        out_ready = 1'b1;
        send_frame(q_num, 0, 1'b1, stall);
        send_frame(q_a, 0, 1'b1, stall);
        check("b2b_stall", 32'(stall), 32'd1);
        wait_xfer(0);
        check("num_crc", xfer_crc[$-1], 32'hCBF43926);
        check("num_len", 32'(xfer_len[$-1]), 32'd9);
        check("num_len_sat", 32'(xfer_len2[$-1]), 32'd3);
        check("b2b_a_crc", xfer_crc[$], 32'hE8B7BE43);
        @(posedge clk); #1;

        send_frame(q_zero, 0, 1'b1, stall);
        repeat (5) begin @(posedge clk); #1; end
        check("hold_valid", {31'h0, out_valid}, 32'd1);
        check("hold_in_ready", {31'h0, in_ready}, 32'd0);
        check("hold_crc", out_crc, 32'hD202EF8D);
        wait_xfer(0);
        check("zero_crc", xfer_crc[$], 32'hD202EF8D);

        send_frame(q_num, 50, 1'b1, stall);
        wait_xfer(2);
        check("gap_crc", xfer_crc[$], 32'hCBF43926);
        check("gap_len_sat", 32'(xfer_len2[$]), 32'd3);

        send_frame(q_part, 0, 1'b0, stall);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_crc", out_crc, 32'h0);
        check("midrst_out_len", {16'h0, out_len}, 32'd0);
        @(posedge clk); #1;
        send_frame(q_a, 0, 1'b1, stall);
        wait_xfer(1);
        check("midrst_a_crc", xfer_crc[$], 32'hE8B7BE43);
        check("midrst_a_len", 32'(xfer_len[$]), 32'd1);

`ifdef CRC32_CHECK_EN
        q_chk = q_num;
        q_chk.push_back(8'h26); q_chk.push_back(8'h39); q_chk.push_back(8'hF4); q_chk.push_back(8'hCB);
        send_frame(q_chk, 20, 1'b1, stall);
        wait_xfer(1);
        check("resid_ok", {31'h0, xfer_ok[$]}, 32'd1);
        check("resid_crc", xfer_crc[$], 32'h2144DF1C);
        q_chk[$] = 8'hCA;
        send_frame(q_chk, 0, 1'b1, stall);
        wait_xfer(0);
        check("resid_bad_ok", {31'h0, xfer_ok[$]}, 32'd0);
`endif

        for (int f = 0; f < 40; f++) begin
            q_rnd.delete();
            for (int i = 0; i < int'($urandom_range(1, 12)); i++) q_rnd.push_back(8'($urandom));
            out_ready = 1'($urandom_range(3) == 0);
            send_frame(q_rnd, 30, 1'b1, stall);
            wait_xfer(int'($urandom_range(3)));
            check("rnd_crc", xfer_crc[$], crc_of(q_rnd));
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/crc32_stream_ctrl.md
# crc32_stream_ctrl

Framed streaming controller for the CRC-32 byte datapath: accepts a byte stream over a valid/ready handshake, sequences one byte-update step per accepted byte against a running 32-bit CRC register, and presents the finished IEEE 802.3 CRC-32 (reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final inversion) plus the frame length on an output handshake. It sits between a byte producer such as a packet buffer or UART and any consumer of frame checksums. The block turns the single-byte combinational update into a multi-byte, back-pressured engine.

## Interface
- LEN_W, 16: width of the frame byte counter, minimum 1.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  byte on in_data is offered.
- in_data  input  8  message byte.
- in_last  input  1  qualifies in_valid; the offered byte is the final byte of the frame.
- in_ready  output  1  block accepts a byte this cycle.
- out_valid  output  1  result is held for the consumer.
- out_crc  output  32  finished CRC, already inverted.
- out_len  output  LEN_W  bytes in the frame, saturating.
- out_ready  input  1  consumer takes the result.
- out_ok  output  1  residue-check flag; present only with CRC32_CHECK_EN.

## Operation
- Accept: in_valid && in_ready. Result transfer: out_valid && out_ready.
- Running register crc_q, raw and not inverted. Update per accepted byte: crc_q <= step(seed, in_data).
  - Seed is 0xFFFFFFFF for the first byte of a frame (IDLE).
  - Seed is crc_q otherwise.
- step applies 8 LSB-first iterations: crc = (crc >> 1) ^ (crc[0] ? 0xEDB88320 : 0). The byte is XORed into crc[7:0] first.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. An accept loads crc_q from the seed and sets len_q=1. The next state is DONE if in_last, else RUN.
  - RUN: in_ready=1, out_valid=0. Each accept updates crc_q and increments len_q. The next state is DONE if in_last.
  - DONE: in_ready=0, out_valid=1. crc_q and len_q are frozen. A result transfer returns to IDLE.
- out_crc = ~crc_q; out_len = len_q. Both are stable the whole time out_valid=1.
- len_q saturates at 2^LEN_W-1. The CRC is still computed over every byte.
- A frame is always at least 1 byte. There are no empty frames.
- in_data and in_last are ignored when no accept occurs.
- Reset mid-frame discards the partial CRC and length and returns to IDLE.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_crc=0x00000000 (crc_q reset to 0xFFFFFFFF), out_len=0, out_ok=0.
- Throughput: 1 byte per cycle in IDLE and RUN.
- Latency: out_valid rises the cycle after the in_last byte is accepted.
- out_valid holds until out_ready. out_valid must not drop, and out_crc/out_len must not change, before the transfer.
- After the transfer, in_ready=1 on the next cycle. This gives exactly one non-accepting cycle minimum between frames; there is no same-cycle pass-through.
- in_ready does not depend combinationally on in_valid. out_valid does not depend combinationally on out_ready.

## Configuration
- CRC32_CHECK_EN defined:
  - Adds output out_ok = (crc_q == 0xDEBB20E3), valid with out_valid.
  - This means the frame had its own CRC appended little-endian and it checks.
- CRC32_CHECK_EN undefined: the out_ok port and its logic are absent.

## Structure
- Package crc32_pkg holds:
  - CRC32_POLY = 32'hEDB88320;
  - CRC32_INIT = 32'hFFFFFFFF;
  - CRC32_RESIDUE = 32'hDEBB20E3;
  - the state enum typedef {IDLE, RUN, DONE}.
- Sub-module crc32_byte_step: purely combinational, with crc_in[31:0] and data[7:0] in, crc_out[31:0] out, implementing the unrolled 8-step update. It has one instance.

## Test plan
- Single-byte frame 0x61 with in_last -> out_crc=0xE8B7BE43 and out_len=1, with out_valid high the next cycle.
- Frame "123456789" (0x31..0x39), back-to-back, out_ready held 1 -> out_crc=0xCBF43926 and out_len=9. in_ready=0 for exactly one cycle, then the next frame is accepted.
- Single byte 0x00 with out_ready=0 for 5 cycles -> out_crc=0xD202EF8D held stable. in_ready=0 throughout, then IDLE after the transfer.
- Random in_valid gaps on "123456789" -> same result 0xCBF43926. LEN_W=2 with the same frame -> out_len=3 (saturated) and CRC unchanged.
- rst asserted after 4 bytes of "123456789", then "a" sent -> out_crc=0xE8B7BE43 and out_len=1.
- With CRC32_CHECK_EN, "123456789" followed by 0x26,0x39,0xF4,0xCB -> out_ok=1 and out_crc=0x2144DF1C. A corrupted final byte -> out_ok=0.
